// File: rtl/recursion_bank_if.sv
// Bus bundle for recursion_bank: sample stream in/out, coefficient and state
// write ports, and the sticky overflow status.
interface recursion_bank_if #(
  parameter int CH = 4,
  parameter int DW = 16,
  parameter int CW = 16
);
  localparam int CHW = $clog2(CH);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_r;
  logic signed [DW-1:0] in_i;

  logic                 coef_we;
  logic [CHW-1:0]       coef_ch;
  logic signed [CW-1:0] coef_r;
  logic signed [CW-1:0] coef_i;

  logic                 init_we;
  logic [CHW-1:0]       init_ch;
  logic signed [DW-1:0] init_r;
  logic signed [DW-1:0] init_i;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_r;
  logic signed [DW-1:0] out_i;
  logic [CHW-1:0]       out_ch;
  logic                 ovf;

  modport master (
    output in_valid, in_r, in_i,
    output coef_we, coef_ch, coef_r, coef_i,
    output init_we, init_ch, init_r, init_i,
    output out_ready,
    input  in_ready, out_valid, out_r, out_i, out_ch, ovf
  );

  modport slave (
    input  in_valid, in_r, in_i,
    input  coef_we, coef_ch, coef_r, coef_i,
    input  init_we, init_ch, init_r, init_i,
    input  out_ready,
    output in_ready, out_valid, out_r, out_i, out_ch, ovf
  );
endinterface

// File: rtl/recursion_bank.sv
// Round-robin bank of CH complex first-order recursions y = a*y[n-1] + x,
// sharing one pipelined complex multiplier, with saturation and sticky ovf.
module recursion_bank #(
  parameter int CH = 4,
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int CF = 14
) (
  input logic             clk,
  input logic             rst,
  recursion_bank_if.slave bus
);
  localparam int CHW = $clog2(CH);
  localparam int MW  = DW + CW;
  localparam int PW  = DW + CW + 1;
  localparam int SW  = PW + 1;

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] Y_MAX   = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] Y_MIN   = {1'b1, {(DW-1){1'b0}}};

  // Writeback lands two advances after accept; a channel must not recur sooner.
  if (CH < 2 || CH > 64) begin : g_ch_check
    $error("recursion_bank: CH must be in 2..64");
  end
  if (CF < 1) begin : g_cf_check
    $error("recursion_bank: CF must be at least 1");
  end

  function automatic logic signed [PW-1:0] round_cf(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] half;
    half = PW'(1) <<< (CF - 1);
    return (p + half) >>> CF;
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
    logic signed [DW-1:0] r;
    if (v > SAT_MAX)      r = Y_MAX;
    else if (v < SAT_MIN) r = Y_MIN;
    else                  r = v[DW-1:0];
    return r;
  endfunction

  function automatic logic clips(input logic signed [SW-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  logic signed [DW-1:0] st_r [CH];
  logic signed [DW-1:0] st_i [CH];
  logic signed [CW-1:0] cf_r [CH];
  logic signed [CW-1:0] cf_i [CH];

  logic [CHW-1:0]       in_ch;
  logic                 adv, accept;
  logic                 vld_p0, vld_p1, vld_p2;
  logic signed [DW-1:0] x_r_p0, x_i_p0, x_r_p1, x_i_p1;
  logic [CHW-1:0]       ch_p0, ch_p1, ch_p2;
  logic signed [PW-1:0] prod_r_p1, prod_i_p1;
  logic signed [DW-1:0] y_r_p2, y_i_p2;
  logic                 ovf_q;

  logic signed [MW-1:0] s_r, s_i, a_r, a_i;
  logic signed [PW-1:0] prod_r, prod_i;
  logic signed [SW-1:0] sum_r, sum_i;

  assign adv          = bus.out_ready | ~vld_p2;
  assign accept       = adv & bus.in_valid;
  assign bus.in_ready = adv;

  // p0 -> p1: state/coefficient read for the captured channel, complex product
  always_comb begin
    s_r    = MW'(st_r[ch_p0]);
    s_i    = MW'(st_i[ch_p0]);
    a_r    = MW'(cf_r[ch_p0]);
    a_i    = MW'(cf_i[ch_p0]);
    prod_r = PW'(s_r * a_r) - PW'(s_i * a_i);
    prod_i = PW'(s_r * a_i) + PW'(s_i * a_r);
  end

  // p1 -> p2: round, add x, saturate
  always_comb begin
    sum_r = SW'(round_cf(prod_r_p1)) + SW'(x_r_p1);
    sum_i = SW'(round_cf(prod_i_p1)) + SW'(x_i_p1);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      x_r_p0 <= bus.in_r;
      x_i_p0 <= bus.in_i;
      ch_p0  <= in_ch;
    end
    if (adv && vld_p0) begin
      prod_r_p1 <= prod_r;
      prod_i_p1 <= prod_i;
      x_r_p1    <= x_r_p0;
      x_i_p1    <= x_i_p0;
      ch_p1     <= ch_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ch  <= '0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      ovf_q  <= 1'b0;
      ch_p2  <= '0;
      y_r_p2 <= '0;
      y_i_p2 <= '0;
      for (int k = 0; k < CH; k++) begin
        st_r[k] <= '0;
        st_i[k] <= '0;
        cf_r[k] <= '0;
        cf_i[k] <= '0;
      end
    end else begin
      if (accept) in_ch <= (in_ch == CHW'(CH - 1)) ? '0 : in_ch + CHW'(1);
      if (adv) begin
        vld_p0 <= bus.in_valid;
        vld_p1 <= vld_p0;
        vld_p2 <= vld_p1;
      end
      if (adv && vld_p1) begin
        y_r_p2      <= sat(sum_r);
        y_i_p2      <= sat(sum_i);
        ch_p2       <= ch_p1;
        st_r[ch_p1] <= sat(sum_r);
        st_i[ch_p1] <= sat(sum_i);
        if (clips(sum_r) || clips(sum_i)) ovf_q <= 1'b1;
      end
      if (bus.coef_we) begin
        cf_r[bus.coef_ch] <= bus.coef_r;
        cf_i[bus.coef_ch] <= bus.coef_i;
      end
      // Placed after the writeback so an init to the same channel wins.
      if (bus.init_we) begin
        st_r[bus.init_ch] <= bus.init_r;
        st_i[bus.init_ch] <= bus.init_i;
      end
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.out_r     = y_r_p2;
  assign bus.out_i     = y_i_p2;
  assign bus.out_ch    = ch_p2;
  assign bus.ovf       = ovf_q;
endmodule
